// File: rtl/raster_timing_gen.sv
// Raster scan timing generator: h/v counters, syncs, active-video qualifier and pixel coordinates.
// Optional frame counter output is enabled by defining RASTER_FRAME_CNT_EN.
module raster_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic        run,
  output logic        hsync,
  output logic        vsync,
  output logic        enable,
  output logic [10:0] gr_x,
  output logic [9:0]  gr_y,
  output logic        line_start,
  output logic        frame_start
`ifdef RASTER_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        h_act, v_act, h_sync_ph, v_sync_ph, h_wrap, v_wrap, en_next, fs_next;

  always_comb begin
    h_act     = (h_cnt < H_ACT_END);
    v_act     = (v_cnt < V_ACT_END);
    h_sync_ph = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    v_sync_ph = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    h_wrap    = (h_cnt == H_LAST);
    v_wrap    = (v_cnt == V_LAST);
    en_next   = h_act && v_act;
    fs_next   = (h_cnt == 11'd0) && (v_cnt == 10'd0);
  end

  // Outputs are decoded from the counter value before it advances, so every
  // output carries the same one-qualified-cycle latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      enable      <= 1'b0;
      gr_x        <= '0;
      gr_y        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      if (!run) begin
        h_cnt       <= '0;
        v_cnt       <= '0;
        hsync       <= ~H_POL;
        vsync       <= ~V_POL;
        enable      <= 1'b0;
        gr_x        <= '0;
        gr_y        <= '0;
        line_start  <= 1'b0;
        frame_start <= 1'b0;
      end else begin
        hsync       <= h_sync_ph ? H_POL : ~H_POL;
        vsync       <= v_sync_ph ? V_POL : ~V_POL;
        enable      <= en_next;
        gr_x        <= en_next ? h_cnt : 11'd0;
        gr_y        <= en_next ? v_cnt : 10'd0;
        line_start  <= (h_cnt == 11'd0) && v_act;
        frame_start <= fs_next;
        if (h_wrap) begin
          h_cnt <= '0;
          v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 11'd1;
        end
      end
    end
  end

`ifdef RASTER_FRAME_CNT_EN
  // Counts up together with the frame_start pulse, so the first frame reads 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (pix_ce && run && fs_next) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_raster_timing_gen.sv
// Randomized self-checking bench for raster_timing_gen using a small raster geometry
// and a frame-position reference model feeding an expected-output queue.
module tb_raster_timing_gen;

  localparam int   HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int   VA = 5, VF = 1, VS = 2, VB = 1;
  localparam logic HP = 1'b0, VP = 1'b1;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   FT = HT * VT;
  localparam int   W  = 42;
`ifdef RASTER_FRAME_CNT_EN
  localparam bit   FC_EN = 1'b1;
`else
  localparam bit   FC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pix_ce = 1'b0;
  logic        run = 1'b0;
  logic        hsync, vsync, enable, line_start, frame_start;
  logic [10:0] gr_x;
  logic [9:0]  gr_y;
  logic [15:0] frame_cnt_s;

  raster_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HP), .V_POL(VP)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .run(run),
    .hsync(hsync), .vsync(vsync), .enable(enable),
    .gr_x(gr_x), .gr_y(gr_y),
    .line_start(line_start), .frame_start(frame_start)
`ifdef RASTER_FRAME_CNT_EN
    , .frame_cnt(frame_cnt_s)
`endif
  );

`ifndef RASTER_FRAME_CNT_EN
  assign frame_cnt_s = 16'h0000;
`endif

  always #5 clk = ~clk;

  wire [W-1:0] dut_vec = {hsync, vsync, enable, gr_x, gr_y, line_start, frame_start, frame_cnt_s};

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  int vectors = 0;
  int miscompares = 0;
  int pos = 0;
  int fc = 0;

  function automatic logic [W-1:0] idle_vec(input int f);
    return {~HP, ~VP, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 16'(FC_EN ? f : 0)};
  endfunction

  // Expected outputs for frame position p (pixels since (0,0)).
  function automatic logic [W-1:0] decode(input int p, input int f);
    int   x, y;
    logic en, hs, vs;
    x  = p % HT;
    y  = p / HT;
    en = (x < HA) && (y < VA);
    hs = (x >= HA + HF && x < HA + HF + HS) ? HP : ~HP;
    vs = (y >= VA + VF && y < VA + VF + VS) ? VP : ~VP;
    return {hs, vs, en, en ? 11'(x) : 11'd0, en ? 10'(y) : 10'd0,
            (x == 0) && (y < VA), p == 0, 16'(FC_EN ? f : 0)};
  endfunction

  task automatic model_step();
    if (!reset) begin
      pos = 0;
      fc = 0;
      last_exp = idle_vec(0);
    end else if (pix_ce) begin
      if (!run) begin
        pos = 0;
        last_exp = idle_vec(fc);
      end else begin
        if (pos == 0) fc = (fc + 1) % 65536;
        last_exp = decode(pos, fc);
        pos = (pos + 1) % FT;
      end
    end
    exp_q.push_back(last_exp);
  endtask

  task automatic cycle(input logic ce, input logic r, input logic rs);
    @(negedge clk);
    pix_ce = ce;
    run = r;
    reset = rs;
    @(posedge clk);
    model_step();
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (dut_vec !== e) begin
          miscompares++;
          $display("FAIL raster_out t=%0t got=%h exp=%h", $time, dut_vec, e);
        end
      end
    end
  end

  initial begin : driver
    last_exp = idle_vec(0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    repeat (2 * FT + 10) cycle(1'b1, 1'b1, 1'b1);
    repeat (400) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    repeat (37) cycle(1'b1, 1'b1, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, 1'b1);
    repeat (600) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0, 1'b1);
    repeat (47) cycle(1'b1, 1'b1, 1'b1);

    // Asynchronous reset between clock edges must clear outputs without an edge.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (dut_vec !== idle_vec(0)) begin
      miscompares++;
      $display("FAIL async_reset got=%h exp=%h", dut_vec, idle_vec(0));
    end
    pos = 0;
    fc = 0;
    last_exp = idle_vec(0);
    repeat (2) cycle(1'b1, 1'b1, 1'b0);
    repeat (FT + 20) cycle(1'b1, 1'b1, 1'b1);
    repeat (300) cycle($urandom_range(0, 2) != 0, $urandom_range(0, 31) != 0, 1'b1);

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
